// File: rtl/up_dn_counter_lim_pkg.sv
// Shared definitions for the limited up/down counter: mode encoding and a
// helper that clamps a value into an inclusive range.
package up_dn_counter_lim_pkg;

    localparam logic WRAP_MODE = 1'b1;
    localparam logic SAT_MODE  = 1'b0;

    // Operands are widened to 32 bits so one function serves any WIDTH <= 32.
    function automatic logic [31:0] clamp(input logic [31:0] value,
                                          input logic [31:0] lo,
                                          input logic [31:0] hi);
        if (value < lo)
            return lo;
        else if (value > hi)
            return hi;
        else
            return value;
    endfunction

endpackage

// File: rtl/up_dn_limit_chk.sv
// Combinational step/limit evaluation: next count value plus overflow,
// underflow and out-of-range indications, computed in WIDTH+1 bits.
module up_dn_limit_chk #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] i_cnt,
    input  logic [WIDTH-1:0] i_step,
    input  logic [WIDTH-1:0] i_min,
    input  logic [WIDTH-1:0] i_max,
    input  logic             i_up,
    output logic [WIDTH-1:0] o_next,
    output logic             o_over,
    output logic             o_under,
    output logic             o_out_of_range
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_diff;

    assign w_sum  = {1'b0, i_cnt} + {1'b0, i_step};
    assign w_diff = {1'b0, i_cnt} - {1'b0, i_step};

    assign o_next  = i_up ? w_sum[WIDTH-1:0] : w_diff[WIDTH-1:0];
    assign o_over  = i_up && (w_sum > {1'b0, i_max});
    // A borrow out of the extended subtraction means the result went negative.
    assign o_under = !i_up && (w_diff[WIDTH] || (w_diff[WIDTH-1:0] < i_min));
    assign o_out_of_range = (i_cnt < i_min) || (i_cnt > i_max);

endmodule

// File: rtl/up_dn_counter_lim.sv
// Up/down counter with programmable limits, step and saturate/wrap mode.
// Optional wrap-event counter output enabled by defining UP_DN_WRAP_CNT_EN.
module up_dn_counter_lim
    import up_dn_counter_lim_pkg::*;
#(
    parameter int               WIDTH      = 5,
    parameter logic [WIDTH-1:0] RESET_VAL  = '0,
    parameter int               WRAP_CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] IN,
    input  logic             UP,
    input  logic             DOWN,
    input  logic [WIDTH-1:0] STEP,
    input  logic [WIDTH-1:0] MIN_LIM,
    input  logic [WIDTH-1:0] MAX_LIM,
    input  logic             WRAP,
`ifdef UP_DN_WRAP_CNT_EN
    output logic [WRAP_CNT_W-1:0] WRAP_CNT,
`endif
    output logic [WIDTH-1:0] COUNTER,
    output logic             LOW,
    output logic             HIGH,
    output logic             TC,
    output logic             LIM_ERR
);

    logic [WIDTH-1:0] r_counter;
    logic             r_tc;
    logic [WIDTH-1:0] w_cnt_next;
    logic             w_tc_next;
    logic             w_wrap_evt;
    logic             w_lim_err;
    logic             w_dir_up;
    logic [WIDTH-1:0] w_step_val;
    logic             w_over;
    logic             w_under;
    logic             w_oor;
    logic [WIDTH-1:0] w_load_val;
    logic [WIDTH-1:0] w_target;

    assign w_lim_err  = MIN_LIM > MAX_LIM;
    assign w_dir_up   = !DOWN;
    assign w_load_val = WIDTH'(clamp(32'(IN), 32'(MIN_LIM), 32'(MAX_LIM)));

    up_dn_limit_chk #(.WIDTH(WIDTH)) u_chk (
        .i_cnt          (r_counter),
        .i_step         (STEP),
        .i_min          (MIN_LIM),
        .i_max          (MAX_LIM),
        .i_up           (w_dir_up),
        .o_next         (w_step_val),
        .o_over         (w_over),
        .o_under        (w_under),
        .o_out_of_range (w_oor)
    );

    always_comb begin
        w_cnt_next = r_counter;
        w_tc_next  = 1'b0;
        w_wrap_evt = 1'b0;
        w_target   = w_dir_up ? MAX_LIM : MIN_LIM;
        if (w_lim_err) begin
            w_cnt_next = r_counter;
        end else if (LOAD) begin
            w_cnt_next = w_load_val;
        end else if (EN && (UP || DOWN) && (STEP != '0)) begin
            if (w_oor) begin
                w_cnt_next = w_dir_up ? MIN_LIM : MAX_LIM;
            end else if (w_over || w_under) begin
                if (WRAP == WRAP_MODE) begin
                    w_cnt_next = w_dir_up ? MIN_LIM : MAX_LIM;
                    w_tc_next  = 1'b1;
                    w_wrap_evt = 1'b1;
                end else begin
                    // Pulse only on arrival at the limit, not while parked there.
                    w_cnt_next = w_target;
                    w_tc_next  = (r_counter != w_target);
                end
            end else begin
                w_cnt_next = w_step_val;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_counter <= RESET_VAL;
            r_tc      <= 1'b0;
        end else begin
            r_counter <= w_cnt_next;
            r_tc      <= w_tc_next;
        end
    end

`ifdef UP_DN_WRAP_CNT_EN
    logic [WRAP_CNT_W-1:0] r_wrap_cnt;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_wrap_cnt <= '0;
        end else if (!w_lim_err && LOAD) begin
            r_wrap_cnt <= '0;
        end else if (w_wrap_evt && (r_wrap_cnt != '1)) begin
            r_wrap_cnt <= r_wrap_cnt + 1'b1;
        end
    end

    assign WRAP_CNT = r_wrap_cnt;
`else
    logic w_unused;
    assign w_unused = w_wrap_evt;
`endif

    assign COUNTER = r_counter;
    assign TC      = r_tc;
    assign LOW     = (r_counter == MIN_LIM);
    assign HIGH    = (r_counter == MAX_LIM);
    assign LIM_ERR = w_lim_err;

endmodule

// File: tb/tb_up_dn_counter_lim.sv
// Directed bench for up_dn_counter_lim (WIDTH=5, RESET_VAL=0); WRAP_CNT checks
// are included when UP_DN_WRAP_CNT_EN is defined.
module tb_up_dn_counter_lim;

    localparam int W = 5;

    logic         CLK = 1'b0;
    logic         RST;
    logic         EN;
    logic         LOAD;
    logic [W-1:0] IN;
    logic         UP;
    logic         DOWN;
    logic [W-1:0] STEP;
    logic [W-1:0] MIN_LIM;
    logic [W-1:0] MAX_LIM;
    logic         WRAP;
    logic [W-1:0] COUNTER;
    logic         LOW;
    logic         HIGH;
    logic         TC;
    logic         LIM_ERR;
`ifdef UP_DN_WRAP_CNT_EN
    logic [7:0]   WRAP_CNT;
`endif

    int n_vec = 0;
    int n_err = 0;

    up_dn_counter_lim #(.WIDTH(W), .RESET_VAL(5'd0), .WRAP_CNT_W(8)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .EN      (EN),
        .LOAD    (LOAD),
        .IN      (IN),
        .UP      (UP),
        .DOWN    (DOWN),
        .STEP    (STEP),
        .MIN_LIM (MIN_LIM),
        .MAX_LIM (MAX_LIM),
        .WRAP    (WRAP),
`ifdef UP_DN_WRAP_CNT_EN
        .WRAP_CNT(WRAP_CNT),
`endif
        .COUNTER (COUNTER),
        .LOW     (LOW),
        .HIGH    (HIGH),
        .TC      (TC),
        .LIM_ERR (LIM_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
        $display("vec %0d %s: observed %0d expected %0d", n_vec, tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST = 1'b0; EN = 1'b0; LOAD = 1'b0; IN = '0; UP = 1'b0; DOWN = 1'b0;
        STEP = 5'd1; MIN_LIM = 5'd3; MAX_LIM = 5'd20; WRAP = 1'b0;
        #12;
        check("reset_counter", COUNTER, 0);
        check("reset_tc", TC, 0);
        RST = 1'b1;

        // Counting from 0 (below MIN) first snaps to MIN, then steps.
        EN = 1'b1; UP = 1'b1;
        tick(); check("oor_snap_min", COUNTER, 3);
        check("oor_snap_tc", TC, 0);
        tick(); check("step_up_1", COUNTER, 4);
        #2 RST = 1'b0;
        #1 check("async_reset", COUNTER, 0);
        RST = 1'b1; EN = 1'b0; UP = 1'b0;

        LOAD = 1'b1; IN = 5'd12;
        tick(); check("load_12", COUNTER, 12);
        IN = 5'd25;
        tick(); check("load_clamp_20", COUNTER, 20);
        check("high_at_max", HIGH, 1);

        // Saturate up: 18 + 4 = 22 > 20.
        IN = 5'd18;
        tick(); LOAD = 1'b0; EN = 1'b1; UP = 1'b1; STEP = 5'd4; WRAP = 1'b0;
        tick(); check("sat_up_cnt", COUNTER, 20);
        check("sat_up_tc", TC, 1);
        tick(); check("sat_park_cnt", COUNTER, 20);
        check("sat_park_tc", TC, 0);

        // Wrap down: 6 - 5 = 1 < 3 -> reload MAX.
        EN = 1'b0; LOAD = 1'b1; IN = 5'd6;
        tick();
`ifdef UP_DN_WRAP_CNT_EN
        check("wrap_cnt_cleared", WRAP_CNT, 0);
`endif
        LOAD = 1'b0; EN = 1'b1; UP = 1'b0; DOWN = 1'b1; STEP = 5'd5; WRAP = 1'b1;
        tick(); check("wrap_dn_cnt", COUNTER, 20);
        check("wrap_dn_tc", TC, 1);
`ifdef UP_DN_WRAP_CNT_EN
        check("wrap_cnt_1", WRAP_CNT, 1);
`endif
        EN = 1'b0;
        tick(); check("tc_one_cycle", TC, 0);

        // Priority: LOAD beats everything and ignores EN; DOWN beats UP.
        LOAD = 1'b1; UP = 1'b1; DOWN = 1'b1; EN = 1'b0; IN = 5'd7;
        tick(); check("prio_load", COUNTER, 7);
        LOAD = 1'b0; EN = 1'b1; STEP = 5'd1; WRAP = 1'b0;
        tick(); check("prio_down", COUNTER, 6);

        // Full-width: 31 + 31 must not wrap modulo 32 silently.
        MIN_LIM = 5'd0; MAX_LIM = 5'd31; EN = 1'b0; UP = 1'b0; DOWN = 1'b0;
        LOAD = 1'b1; IN = 5'd31;
        tick(); LOAD = 1'b0; EN = 1'b1; UP = 1'b1; STEP = 5'd31; WRAP = 1'b1;
        tick(); check("fullw_cnt", COUNTER, 0);
        check("fullw_tc", TC, 1);
        check("fullw_low", LOW, 1);
        check("fullw_high", HIGH, 0);

        // Limit error: counter frozen under LOAD and UP.
        EN = 1'b0; UP = 1'b0; LOAD = 1'b1; IN = 5'd2;
        tick(); check("load_2", COUNTER, 2);
        MIN_LIM = 5'd10; MAX_LIM = 5'd5; IN = 5'd7;
        #1 check("lim_err_flag", LIM_ERR, 1);
        tick(); check("lim_err_load", COUNTER, 2);
        LOAD = 1'b0; EN = 1'b1; UP = 1'b1; STEP = 5'd1;
        tick(); check("lim_err_up", COUNTER, 2);
        check("lim_err_tc", TC, 0);

        MIN_LIM = 5'd10; MAX_LIM = 5'd15;
        #1 check("lim_err_clear", LIM_ERR, 0);
        tick(); check("restore_snap", COUNTER, 10);
        check("restore_tc", TC, 0);

        // Degenerate range MIN == MAX.
        MAX_LIM = 5'd10; WRAP = 1'b0;
        #1 check("eq_low", LOW, 1);
        check("eq_high", HIGH, 1);
        tick(); check("eq_sat_cnt", COUNTER, 10);
        check("eq_sat_tc", TC, 0);
        WRAP = 1'b1;
        tick(); check("eq_wrap_cnt", COUNTER, 10);
        check("eq_wrap_tc", TC, 1);

        // STEP=0 holds without a pulse.
        STEP = 5'd0; MAX_LIM = 5'd15;
        tick(); check("step0_cnt", COUNTER, 10);
        check("step0_tc", TC, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/up_dn_counter_lim.md
Name: up_dn_counter_lim

Overview:
Parametrised up/down counter with runtime-programmable lower and upper limits, a variable step size, and a selectable saturate or wrap mode.
- Successor to the fixed 5-bit load/up/down counter; same priority scheme (LOAD > DOWN > UP).
- Adds an enable, limit and terminal-count flags, a registered terminal-count pulse, and a limit-error flag.
- Used as a general event/position counter in control datapaths.

Parameters:
WIDTH, 5, counter, limit, load and step width in bits
RESET_VAL, 0, COUNTER value on reset (WIDTH bits)
WRAP_CNT_W, 8, width of the optional wrap-event counter

Ports:
CLK  input  1  clock, rising edge
RST  input  1  asynchronous active-low reset
EN  input  1  count enable; gates UP/DOWN only, not LOAD
LOAD  input  1  synchronous load of IN
IN  input  WIDTH  load value
UP  input  1  count up request
DOWN  input  1  count down request
STEP  input  WIDTH  increment/decrement magnitude, unsigned
MIN_LIM  input  WIDTH  lower limit, unsigned, inclusive
MAX_LIM  input  WIDTH  upper limit, unsigned, inclusive
WRAP  input  1  1 = wrap at limits, 0 = saturate
COUNTER  output  WIDTH  registered count
LOW  output  1  comb: COUNTER == MIN_LIM
HIGH  output  1  comb: COUNTER == MAX_LIM
TC  output  1  registered one-cycle terminal-count pulse
LIM_ERR  output  1  comb: MIN_LIM > MAX_LIM

Behaviour:
- Reset (RST=0, async): COUNTER=RESET_VAL, TC=0, optional WRAP_CNT=0. Release is synchronous to the next CLK edge.
- Priority per edge:
  - LIM_ERR=1: COUNTER holds, TC=0. LOAD is also ignored.
  - LOAD: COUNTER=clamp(IN, MIN_LIM, MAX_LIM), TC=0. EN is ignored.
  - EN && DOWN: count down; UP is ignored.
  - EN && UP && !DOWN: count up.
  - Otherwise: hold, TC=0.
- Arithmetic is done in WIDTH+1 bits with no modular overflow of WIDTH.
  - Up: next = COUNTER + STEP.
  - Down: next = COUNTER - STEP; negative is treated as below MIN_LIM.
- Up, next <= MAX_LIM: COUNTER=next, TC=0.
- Up, next > MAX_LIM:
  - Saturate mode: COUNTER=MAX_LIM. TC=1 only if COUNTER != MAX_LIM before the edge (no repeated pulse while parked).
  - Wrap mode: COUNTER=MIN_LIM, TC=1 (reload wrap, no residue carried).
- Down, next >= MIN_LIM: COUNTER=next, TC=0.
- Down, next < MIN_LIM: mirror of up.
  - Saturate mode: COUNTER=MIN_LIM, TC=1 only on the first arrival.
  - Wrap mode: COUNTER=MAX_LIM, TC=1.
- STEP=0: counting holds, TC=0.
- COUNTER outside [MIN_LIM, MAX_LIM] at a count event (limits changed at runtime, or RESET_VAL out of range): COUNTER=MIN_LIM for up, MAX_LIM for down, TC=0.
- MIN_LIM == MAX_LIM: LOW=HIGH=1.
  - Saturate: a count holds with TC=0.
  - Wrap: a count reloads the same value with TC=1.
- TC latency: asserted in the cycle after the edge that wrapped or saturated; width is exactly one cycle unless the event repeats.
- LOW, HIGH and LIM_ERR are combinational from COUNTER and the limit ports; no latency.

Optional Feature:
Macro: UP_DN_WRAP_CNT_EN
- Defined:
  - Adds output WRAP_CNT[WRAP_CNT_W-1:0]: a count of wrap events (wrap mode only; saturations are not counted).
  - Increments on the same edge that sets TC in wrap mode.
  - Saturates at all-ones.
  - Cleared by reset and by LOAD.
- Undefined: the port and its register are absent; all other behaviour is identical.

Decomposition:
- Shared package: mode encoding constants (WRAP_MODE=1, SAT_MODE=0) and a clamp function (value, lo, hi).
- One sub-module: up_dn_limit_chk. Combinational; takes COUNTER, STEP, limits and direction; produces next value, over/under flags and out-of-range flag.
- The top holds the registers and priority logic.

Test Plan:
1. Reset/load: WIDTH=5, RST low mid-count -> COUNTER=0 immediately. LOAD IN=12 with limits 3..20 -> COUNTER=12. LOAD IN=25 -> COUNTER=20.
2. Saturate up: limits 3..20, STEP=4, COUNTER=18, UP, WRAP=0 -> COUNTER=20 and TC=1 next cycle. Second UP -> COUNTER=20, TC=0.
3. Wrap down: limits 3..20, STEP=5, COUNTER=6, DOWN, WRAP=1 -> COUNTER=20, TC=1. With UP_DN_WRAP_CNT_EN, WRAP_CNT increments 0->1.
4. Priority: LOAD=1, UP=1, DOWN=1, EN=0, IN=7 -> COUNTER=7. Then UP=DOWN=EN=1, STEP=1 -> COUNTER=6.
5. Full-width overflow: limits 0..31, STEP=31, COUNTER=31, UP, WRAP=1 -> COUNTER=0, TC=1 (no silent modular add). LOW=1, HIGH=0.
6. Limit error/runtime change: MIN_LIM=10, MAX_LIM=5 -> LIM_ERR=1, COUNTER holds under LOAD and UP. Restore limits to 10..15 with COUNTER=2, UP -> COUNTER=10, TC=0.
